// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage hazard scoreboard for the pipelined MIPS core.
// Each tracked register (GPRs, then HI at 32 and LO at 33) has a small
// countdown of cycles until its pending write is available. Decode stalls
// while a source is still too far out, or while a new write would land before
// an older in-flight write to the same register (WAW). A sticky watchdog
// flags a stall that has run for STALL_MAX consecutive cycles.
module id_scoreboard #(
  parameter int NREG      = 34,
  parameter int AW        = 6,
  parameter int MAX_LAT   = 4,
  parameter int LW        = 3,
  parameter int FWD_EN    = 1,
  parameter int ZERO_REG  = 1,
  parameter int STALL_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_src0_en,
  input  logic [AW-1:0]   id_src0,
  input  logic            id_src1_en,
  input  logic [AW-1:0]   id_src1,
  input  logic            id_dst_en,
  input  logic [AW-1:0]   id_dst,
  input  logic [LW-1:0]   id_lat,
  input  logic            flush,
  output logic            stall,
  output logic            issue,
  output logic            fwd0,
  output logic            fwd1,
  output logic [NREG-1:0] busy_vec,
  output logic            stall_timeout
);

  localparam int            RW        = $clog2(STALL_MAX + 1);
  localparam logic [RW-1:0] STALL_L   = RW'(STALL_MAX);
  localparam logic [LW-1:0] MAX_LAT_L = LW'(MAX_LAT);
  // A source is only a hazard while its count exceeds this threshold; with
  // forwarding enabled a count of 1 is served by the bypass network.
  localparam logic [LW-1:0] FWD_L     = LW'(FWD_EN);
  localparam logic [AW:0]   NREG_L    = (AW + 1)'(NREG);

  // Index 0 (when hard-wired to zero) and indices past the table are ignored.
  function automatic logic f_tracked(input logic [AW-1:0] idx);
    return !((ZERO_REG != 0) && (idx == '0)) && ({1'b0, idx} < NREG_L);
  endfunction

  logic [LW-1:0] r_cnt [NREG];
  logic [RW-1:0] r_stall_run;
  logic          r_stall_timeout;

  logic [LW-1:0] w_cnt_s0;
  logic [LW-1:0] w_cnt_s1;
  logic [LW-1:0] w_cnt_dst;
  logic          w_trk_s0;
  logic          w_trk_s1;
  logic          w_trk_dst;
  logic [LW-1:0] w_lat_eff;
  logic          w_busy0;
  logic          w_busy1;
  logic          w_waw;
  logic          w_stall;
  logic          w_issue;
  logic          w_write;
  logic [RW-1:0] w_run_next;

  // Look up the pre-update counts for both sources and the destination.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_cnt_s0  = '0;
    w_cnt_s1  = '0;
    w_cnt_dst = '0;
    for (int r = 0; r < NREG; r++) begin
      if (id_src0 == AW'(r)) w_cnt_s0  = r_cnt[r];
      if (id_src1 == AW'(r)) w_cnt_s1  = r_cnt[r];
      if (id_dst  == AW'(r)) w_cnt_dst = r_cnt[r];
    end
  end

  assign w_trk_s0  = f_tracked(id_src0);
  assign w_trk_s1  = f_tracked(id_src1);
  assign w_trk_dst = f_tracked(id_dst);

  assign w_lat_eff = (id_lat > MAX_LAT_L) ? MAX_LAT_L : id_lat;

  assign w_busy0 = id_src0_en && w_trk_s0 && (w_cnt_s0 > FWD_L);
  assign w_busy1 = id_src1_en && w_trk_s1 && (w_cnt_s1 > FWD_L);
  // A new write must not complete before an older write to the same register.
  assign w_waw   = id_dst_en && w_trk_dst && (id_lat != '0) && (w_cnt_dst > w_lat_eff);

  assign w_stall = id_valid && !flush && (w_busy0 || w_busy1 || w_waw);
  assign w_issue = id_valid && !w_stall && !flush;
  assign w_write = w_issue && id_dst_en && w_trk_dst && (w_lat_eff != '0);

  assign stall = w_stall;
  assign issue = w_issue;
  assign fwd0  = id_valid && (FWD_EN != 0) && id_src0_en && w_trk_s0 && (w_cnt_s0 == LW'(1));
  assign fwd1  = id_valid && (FWD_EN != 0) && id_src1_en && w_trk_s1 && (w_cnt_s1 == LW'(1));

  // Expose which registers still have a write in flight.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_vec[r] = (r_cnt[r] != '0);
    end
  end

  // Age every pending write by one cycle, clear all on flush, then record the
  // newly issued write (which overrides the decrement of its own entry).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the count table is a handful of flops, not a RAM, and must start
      // empty so nothing stalls out of reset; hence it is reset explicitly.
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        // NOTE: non-blocking assignments let the later write to the same entry
        // win cleanly while every read in this block still sees the old value.
        if (flush) begin
          r_cnt[r] <= '0;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
        if (w_write && (id_dst == AW'(r))) begin
          r_cnt[r] <= w_lat_eff;
        end
      end
    end
  end

  // Length of the current stall run, saturating at the watchdog limit.
  assign w_run_next = !w_stall                ? '0 :
                      (r_stall_run == STALL_L) ? r_stall_run :
                                                 r_stall_run + 1'b1;

  // Track consecutive stall cycles and latch the watchdog once the limit is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_run     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_stall_run <= w_run_next;
      if (w_run_next == STALL_L) begin
        r_stall_timeout <= 1'b1;
      end
    end
  end

  assign stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_id_scoreboard.sv
// Testbench for id_scoreboard: directed scenarios followed by random traffic,
// all compared against a per-register countdown model held in plain ints.
module tb_id_scoreboard;

  localparam int NREG      = 34;
  localparam int AW        = 6;
  localparam int MAX_LAT   = 4;
  localparam int LW        = 3;
  localparam int FWD_EN    = 1;
  localparam int ZERO_REG  = 1;
  localparam int STALL_MAX = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic            id_src0_en;
  logic [AW-1:0]   id_src0;
  logic            id_src1_en;
  logic [AW-1:0]   id_src1;
  logic            id_dst_en;
  logic [AW-1:0]   id_dst;
  logic [LW-1:0]   id_lat;
  logic            flush;
  logic            stall;
  logic            issue;
  logic            fwd0;
  logic            fwd1;
  logic [NREG-1:0] busy_vec;
  logic            stall_timeout;

  id_scoreboard #(
    .NREG(NREG), .AW(AW), .MAX_LAT(MAX_LAT), .LW(LW),
    .FWD_EN(FWD_EN), .ZERO_REG(ZERO_REG), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_src0_en(id_src0_en), .id_src0(id_src0),
    .id_src1_en(id_src1_en), .id_src1(id_src1),
    .id_dst_en(id_dst_en), .id_dst(id_dst), .id_lat(id_lat),
    .flush(flush),
    .stall(stall), .issue(issue), .fwd0(fwd0), .fwd1(fwd1),
    .busy_vec(busy_vec), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: cycles remaining per register, stall run, watchdog flag.
  int m_cnt [NREG];
  int m_run;
  bit m_to;

  bit              e_stall;
  bit              e_issue;
  bit              e_fwd0;
  bit              e_fwd1;
  logic [NREG-1:0] e_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit trk(input int idx);
    return !(ZERO_REG != 0 && idx == 0) && idx < NREG;
  endfunction

  function automatic int cnt_of(input int idx);
    return trk(idx) ? m_cnt[idx] : 0;
  endfunction

  function automatic int lat_eff();
    return (int'(id_lat) > MAX_LAT) ? MAX_LAT : int'(id_lat);
  endfunction

  task automatic model_eval();
    bit b0, b1, waw;
    int s0, s1, d;
    s0 = int'(id_src0);
    s1 = int'(id_src1);
    d  = int'(id_dst);
    b0  = id_src0_en && cnt_of(s0) > FWD_EN;
    b1  = id_src1_en && cnt_of(s1) > FWD_EN;
    waw = id_dst_en && trk(d) && id_lat != 0 && cnt_of(d) > lat_eff();
    e_stall = id_valid && !flush && (b0 || b1 || waw);
    e_issue = id_valid && !e_stall && !flush;
    e_fwd0  = id_valid && FWD_EN != 0 && id_src0_en && cnt_of(s0) == 1;
    e_fwd1  = id_valid && FWD_EN != 0 && id_src1_en && cnt_of(s1) == 1;
    for (int r = 0; r < NREG; r++) e_busy[r] = (m_cnt[r] != 0);
  endtask

  task automatic check_all(input string tag);
    model_eval();
    check({tag, ".stall"}, 64'(stall), 64'(e_stall));
    check({tag, ".issue"}, 64'(issue), 64'(e_issue));
    check({tag, ".fwd0"},  64'(fwd0),  64'(e_fwd0));
    check({tag, ".fwd1"},  64'(fwd1),  64'(e_fwd1));
    check({tag, ".busy"},  64'(busy_vec), 64'(e_busy));
    check({tag, ".wdog"},  64'(stall_timeout), 64'(m_to));
  endtask

  // Advance one clock and apply the same step to the model.
  task automatic tick();
    int d;
    model_eval();
    d = int'(id_dst);
    for (int r = 0; r < NREG; r++) begin
      if (flush) m_cnt[r] = 0;
      else if (m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
    end
    if (e_issue && id_dst_en && trk(d) && lat_eff() != 0) m_cnt[d] = lat_eff();
    if (e_stall) m_run = (m_run + 1 > STALL_MAX) ? STALL_MAX : m_run + 1;
    else m_run = 0;
    if (m_run == STALL_MAX) m_to = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit s0e, input int s0, input bit s1e, input int s1,
                       input bit de, input int d, input int lat, input bit fl);
    id_valid   = v;
    id_src0_en = s0e;
    id_src0    = AW'(s0);
    id_src1_en = s1e;
    id_src1    = AW'(s1);
    id_dst_en  = de;
    id_dst     = AW'(d);
    id_lat     = LW'(lat);
    flush      = fl;
    #1;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_run = 0;
    m_to  = 1'b0;

    // Reset for two cycles, released away from the clock edge.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: sources 5/6 read with nothing in flight.
    drive(1, 1, 5, 1, 6, 0, 0, 0, 0);
    check_all("rst");
    check("rst.stall_c", 64'(stall), 64'd0);
    check("rst.issue_c", 64'(issue), 64'd1);
    check("rst.busy_c",  64'(busy_vec), 64'd0);
    check("rst.fwd_c",   64'({fwd1, fwd0}), 64'd0);
    tick();

    // Load-use on r8 with latency 3: count is 3, 2 (stalls), then 1 (forward).
    drive(1, 0, 0, 0, 0, 1, 8, 3, 0);
    check_all("ld.issue");
    tick();
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0);
    check_all("ld.c1");
    check("ld.c1.stall_c", 64'(stall), 64'd1);
    tick();
    check_all("ld.c2");
    check("ld.c2.stall_c", 64'(stall), 64'd1);
    tick();
    check_all("ld.c3");
    check("ld.c3.stall_c", 64'(stall), 64'd0);
    check("ld.c3.fwd0_c",  64'(fwd0), 64'd1);
    tick();
    check_all("ld.c4");
    check("ld.c4.fwd0_c", 64'(fwd0), 64'd0);
    check("ld.c4.busy8_c", 64'(busy_vec[8]), 64'd0);
    // Two consecutive stalls stay below the watchdog limit of 3.
    check("ld.wdog_c", 64'(stall_timeout), 64'd0);
    tick();

    // Zero register is never tracked.
    drive(1, 0, 0, 0, 0, 1, 0, 4, 0);
    check_all("zr.issue");
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check_all("zr.read");
    check("zr.busy0_c", 64'(busy_vec[0]), 64'd0);
    check("zr.stall_c", 64'(stall), 64'd0);
    tick();

    // Out-of-range index is never tracked; oversized latency clamps to MAX_LAT.
    drive(1, 0, 0, 0, 0, 1, 40, 3, 0);
    check_all("oor.issue");
    tick();
    drive(1, 1, 40, 1, 41, 1, 11, 7, 0);
    check_all("oor.read");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("clamp");
    check("clamp.busy11_c", 64'(busy_vec[11]), 64'd1);
    for (int i = 0; i < 4; i++) tick();

    // Watchdog: hold a read of r7 against a latency-4 producer.
    drive(1, 0, 0, 0, 0, 1, 7, 4, 0);
    check_all("wd.issue");
    tick();
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_all("wd.hold");
      check("wd.hold.stall_c", 64'(stall), 64'd1);
      check("wd.hold.wdog_c",  64'(stall_timeout), 64'd0);
      tick();
    end
    check_all("wd.after");
    check("wd.after.stall_c", 64'(stall), 64'd0);
    check("wd.after.wdog_c",  64'(stall_timeout), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("wd.sticky_c", 64'(stall_timeout), 64'd1);

    // WAW on HI: latency 4 in flight, then a latency-1 write waits until count is 1.
    drive(1, 0, 0, 0, 0, 1, 32, 4, 0);
    check_all("waw.first");
    tick();
    drive(1, 0, 0, 0, 0, 1, 32, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check_all("waw.wait");
      check("waw.wait.stall_c", 64'(stall), 64'd1);
      tick();
    end
    check_all("waw.go");
    check("waw.go.issue_c", 64'(issue), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("waw.done");
    check("waw.done.busy32_c", 64'(busy_vec[32]), 64'd1);
    tick();

    // Flush with producers on r10 then r9 in flight.
    drive(1, 0, 0, 0, 0, 1, 10, 3, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 9, 3, 0);
    tick();
    drive(1, 1, 9, 0, 0, 0, 0, 0, 1);
    check_all("fl.cycle");
    check("fl.stall_c", 64'(stall), 64'd0);
    check("fl.issue_c", 64'(issue), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("fl.next");
    check("fl.busy_c", 64'(busy_vec), 64'd0);
    tick();

    // Random traffic, including untracked indices, clamped latencies and flushes.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8,
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 12)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 12)),
            $urandom_range(0, 2) != 0, int'($urandom_range(0, 12)),
            int'($urandom_range(0, 7)),
            $urandom_range(0, 19) == 0);
      if (i % 8 == 0) begin
        id_src0 = AW'($urandom_range(30, 63));
        id_dst  = AW'($urandom_range(30, 63));
        #1;
      end
      check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
